// File: rtl/ofdm_data_scrambler.sv
// 802.11a DATA-field scrambler: SERVICE + data octets + tail/pad, emitted as nibbles.
// Optional `define SCRAMBLER_BYPASS_EN adds a per-frame bypass input.
module ofdm_data_scrambler #(
    parameter logic [6:0]  DEF_SEED = 7'b1011101,
    parameter int unsigned NIB_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       seed_in,
    input  logic [11:0]      length_in,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic             in_valid,
    input  logic [NIB_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [NIB_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {StIdle, StService, StData, StTail, StFlush} state_e;

    state_e           state_q, state_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic [12:0]      cnt_q, cnt_d;
    logic [11:0]      len_q, len_d;
    logic             out_valid_q, out_valid_d;
    logic [NIB_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             advance;
    logic             data_last;
    logic             scr_en;
    logic             fb;
    logic [NIB_W-1:0] src_nib, scr_nib;
    logic [6:0]       lfsr_step;

`ifdef SCRAMBLER_BYPASS_EN
    logic byp_q, byp_d;
    assign scr_en = ~byp_q;
`else
    assign scr_en = 1'b1;
`endif

    assign advance   = !out_valid_q || out_ready;
    assign data_last = (cnt_q == ({len_q, 1'b0} - 13'd1));
    assign src_nib   = (state_q == StData) ? in_data : '0;

    // Four LFSR steps per nibble, bit0 first in time.
    always_comb begin
        lfsr_step = lfsr_q;
        scr_nib   = '0;
        fb        = 1'b0;
        for (int i = 0; i < NIB_W; i++) begin
            fb         = lfsr_step[6] ^ lfsr_step[3];
            scr_nib[i] = src_nib[i] ^ (fb & scr_en);
            lfsr_step  = {lfsr_step[5:0], fb};
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
        byp_d       = byp_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // The cycle carrying done is still IDLE but must not accept a start.
                if (start && length_in != '0 && !done_q) begin
                    lfsr_d  = (seed_in == '0) ? DEF_SEED : seed_in;
                    len_d   = length_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StService;
`ifdef SCRAMBLER_BYPASS_EN
                    byp_d   = bypass;
`endif
                end
            end
            StService: begin
                if (advance) begin
                    out_valid_d = 1'b1;
                    out_data_d  = scr_nib;
                    out_last_d  = 1'b0;
                    lfsr_d      = lfsr_step;
                    cnt_d       = cnt_q + 13'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_d   = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = advance;
                if (in_valid && advance) begin
                    out_valid_d = 1'b1;
                    out_data_d  = scr_nib;
                    out_last_d  = 1'b0;
                    lfsr_d      = lfsr_step;
                    cnt_d       = cnt_q + 13'd1;
                    if (data_last) begin
                        cnt_d   = '0;
                        state_d = StTail;
                    end
                end
            end
            StTail: begin
                if (advance) begin
                    out_valid_d = 1'b1;
                    lfsr_d      = lfsr_step;
                    if (cnt_q == '0) begin
                        out_data_d = '0;
                        out_last_d = 1'b0;
                        cnt_d      = 13'd1;
                    end else begin
                        // Last two tail bits are zero; upper bits are scrambled pad.
                        out_data_d = {scr_nib[3:2], 2'b00};
                        out_last_d = 1'b1;
                        state_d    = StFlush;
                    end
                end
            end
            StFlush: begin
                if (out_valid_q && out_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= 7'h7F;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
            byp_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SCRAMBLER_BYPASS_EN
            byp_q       <= byp_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ofdm_data_scrambler.sv
// Bench for ofdm_data_scrambler: randomized frames checked against a bit-serial
// scrambler model of the whole DATA field.
module tb_ofdm_data_scrambler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  seed_in;
    logic [11:0] length_in;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    ofdm_data_scrambler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed_in   (seed_in),
        .length_in (length_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         busy_cycles;
    logic [3:0] dat_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [3:0] ref_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Whole field as a bit stream: 16 zero SERVICE bits, data bits, 8 zero bits;
    // every bit XORed with the x^7+x^4+1 sequence, then the 6 tail bits cleared.
    task automatic build_expected(input logic [6:0] seed, input int len);
        int unsigned s;
        int          nbits;
        int          dstart;
        int          tstart;
        logic [3:0]  nib;
        logic [3:0]  src;
        logic        din;
        logic        ob;
        int unsigned fbit;
        s      = (seed == 7'd0) ? 32'd93 : 32'(seed);
        dstart = 16;
        tstart = 16 + 8 * len;
        nbits  = tstart + 8;
        nib    = 4'h0;
        exp_q.delete();
        for (int i = 0; i < nbits; i++) begin
            din = 1'b0;
            if (i >= dstart && i < tstart) begin
                src = dat_q[(i - dstart) / 4];
                din = src[(i - dstart) % 4];
            end
            fbit = ((s >> 6) ^ (s >> 3)) & 32'd1;
            s    = ((s << 1) | fbit) & 32'h7F;
            ob   = din ^ fbit[0];
            if (i >= tstart && i < tstart + 6) ob = 1'b0;
            nib[i % 4] = ob;
            if (i % 4 == 3) exp_q.push_back(nib);
        end
    endtask

    // rmode: 0 always ready, 1 toggle 1/0, 2 random. vmode: 0 always valid, 1 random.
    task automatic run_frame(input logic [6:0] seed, input int len, input int rmode,
                             input int vmode, input bit new_data, input bit zero_data,
                             input int busy_start_at, input bit start_at_done);
        int         total;
        int         di;
        bit         finished;
        bit         stalled;
        logic [3:0] prev_data;
        logic       prev_last;
        if (new_data) begin
            dat_q.delete();
            for (int i = 0; i < 2 * len; i++)
                dat_q.push_back(zero_data ? 4'h0 : 4'($urandom_range(15)));
        end
        build_expected(seed, len);
        total       = 4 + 2 * len + 2;
        di          = 0;
        finished    = 1'b0;
        stalled     = 1'b0;
        prev_data   = 4'h0;
        prev_last   = 1'b0;
        busy_cycles = 0;
        got_q.delete();

        @(negedge clk);
        start     = 1'b1;
        seed_in   = seed;
        length_in = len[11:0];
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 8 * total + 50 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0)
                                                           : 1'($urandom_range(1));
            in_valid  = (vmode == 0) ? 1'b1 : 1'($urandom_range(1));
            in_data   = (di < dat_q.size()) ? dat_q[di] : 4'($urandom_range(15));
            start     = (cyc == busy_start_at);
            seed_in   = 7'($urandom);
            length_in = 12'($urandom_range(4095, 1));
            #1;
            if (busy) busy_cycles++;
            if (cyc == 0) chk("busy_after_start", busy, 1);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && !out_ready) chk("in_ready_while_stalled", in_ready, 0);
            if (in_valid && in_ready) di++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                chk("out_last_position", out_last, (got_q.size() == total));
                if (out_last) finished = 1'b1;
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
        start = 1'b0;
        chk("frame_complete", finished, 1);

        @(negedge clk);
        start     = start_at_done;
        seed_in   = 7'h11;
        length_in = 12'd5;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("busy_clear_at_done", busy, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_one_cycle", done, 0);
        chk("start_at_done_ignored", busy, 0);

        chk("nibble_count", got_q.size(), total);
        chk("data_consumed", di, 2 * len);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("nibble[%0d]", i), got_q[i], exp_q[i]);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        start     = 1'b0;
        seed_in   = 7'h0;
        length_in = 12'h0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_out_data", out_data, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Known SERVICE pattern for seed 7F, zero data.
        run_frame(7'h7F, 1, 0, 0, 1, 1, -1, 0);
        chk("svc0", got_q[0], 4'h0);
        chk("svc1", got_q[1], 4'h7);
        chk("svc2", got_q[2], 4'hF);
        chk("svc3", got_q[3], 4'h4);

        // seed 0 falls back to the default seed.
        run_frame(7'h00, 1, 0, 0, 1, 1, -1, 0);
        chk("busy_len1_cycles", busy_cycles >= 8, 1);
        ref_q = got_q;
        run_frame(7'b1011101, 1, 0, 0, 1, 1, -1, 0);
        chk("seed0_size", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            chk("seed0_equals_default", got_q[i], ref_q[i]);

        // Toggling out_ready must not change the stream.
        run_frame(7'h2A, 3, 0, 0, 1, 0, -1, 0);
        ref_q = got_q;
        run_frame(7'h2A, 3, 1, 0, 0, 0, -1, 0);
        chk("toggle_size", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            chk("toggle_equals_flow", got_q[i], ref_q[i]);

        // Random frames, random back-pressure, stray start while busy,
        // start coincident with done.
        for (int f = 0; f < 6; f++)
            run_frame(7'($urandom), $urandom_range(20, 1), 2, 1, 1, 0, 3 + f, (f % 2 == 0));

        // Maximum length, continuous flow.
        run_frame(7'h55, 4095, 0, 0, 1, 0, 100, 0);

        // Abort mid-DATA with reset.
        dat_q.delete();
        @(negedge clk);
        start     = 1'b1;
        seed_in   = 7'h33;
        length_in = 12'd10;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin
            in_data = 4'($urandom_range(15));
            @(negedge clk);
        end
        #1;
        chk("abort_in_data_phase", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", out_data, 4'h0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            seen |= done | busy;
        end
        chk("abort_no_done", seen, 0);
        run_frame(7'h7F, 2, 0, 0, 1, 0, -1, 0);
        chk("post_abort_svc0", got_q[0], 4'h0);
        chk("post_abort_svc1", got_q[1], 4'h7);
        chk("post_abort_svc2", got_q[2], 4'hF);
        chk("post_abort_svc3", got_q[3], 4'h4);

        // Zero-length start is ignored.
        @(negedge clk);
        start     = 1'b1;
        seed_in   = 7'h7F;
        length_in = 12'd0;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        repeat (4) begin
            #1;
            seen |= busy | done | out_valid;
            @(negedge clk);
        end
        chk("len0_ignored", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
